// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx_sched frame scheduler.
// UART_TX_SCHED_CKSUM_EN adds the CKSUM state that appends an XOR checksum byte.
package uart_tx_sched_pkg;
  localparam int BYTE_W        = 8;
  localparam int MAX_BYTES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3
`ifdef UART_TX_SCHED_CKSUM_EN
    , ST_CKSUM = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer registered on each grant.
module rr_arb2 (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt_any,
  output logic gnt_id
);
  // ptr_q names the requester that wins a tie; 0 after reset
  logic ptr_q;

  always_comb begin
    gnt_any = req0 | req1;
    gnt_id  = (req0 & req1) ? ptr_q : req1;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST)
      ptr_q <= 1'b0;
    else if (en && gnt_any)
      ptr_q <= ~gnt_id;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler feeding uart_tx one byte at a time, MSB first.
// Optional UART_TX_SCHED_CKSUM_EN appends the XOR of the payload bytes to each frame.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int LEN_W     = 3
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_REQ0_VALID,
  input  logic [DATA_W-1:0] i_REQ0_DATA,
  input  logic [LEN_W-1:0]  i_REQ0_LEN,
  output logic              o_REQ0_READY,
  input  logic              i_REQ1_VALID,
  input  logic [DATA_W-1:0] i_REQ1_DATA,
  input  logic [LEN_W-1:0]  i_REQ1_LEN,
  output logic              o_REQ1_READY,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic              o_BUSY,
  output logic              o_GRANT_ID,
  output logic [2:0]        o_DBG_STATE
);
  // Requesters: VALID held until a one-cycle READY pulse; DATA/LEN stable meanwhile.
  // uart_tx: o_Tx_DV is a one-cycle strobe; i_Tx_Done high then low completes a byte.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  state_t              state_q, state_d;
  logic                ready0_q, ready1_q, grant_id_q;
  logic [BYTE_W-1:0]   tx_byte_q;
  logic [DATA_W-1:0]   sh_q;
  logic [LEN_W-1:0]    rem_q;
  logic                v0_m, v1_m, arb_en, gnt_any, gnt_id, grant;
  logic [DATA_W-1:0]   data_sel, aligned;
  logic [LEN_W-1:0]    len_sel, len_sat;
  logic                tx_dv, load_next;
`ifdef UART_TX_SCHED_CKSUM_EN
  logic [BYTE_W-1:0]   cksum_q;
  logic                ck_sent_q, load_ck;
`endif

  // A requester still holding VALID during its READY cycle must not be regranted
  assign v0_m   = i_REQ0_VALID & ~ready0_q;
  assign v1_m   = i_REQ1_VALID & ~ready1_q;
  assign arb_en = (state_q == ST_IDLE);
  assign grant  = arb_en & gnt_any;

  rr_arb2 u_arb (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .req0    (v0_m),
    .req1    (v1_m),
    .en      (arb_en),
    .gnt_any (gnt_any),
    .gnt_id  (gnt_id)
  );

  // Left-align the low LEN bytes so bytes always leave from the top of sh_q
  always_comb begin
    data_sel = gnt_id ? i_REQ1_DATA : i_REQ0_DATA;
    len_sel  = gnt_id ? i_REQ1_LEN : i_REQ0_LEN;
    len_sat  = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;
    aligned  = data_sel << (BYTE_W * (MAX_BYTES - int'(len_sat)));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_dv     = 1'b0;
    load_next = 1'b0;
`ifdef UART_TX_SCHED_CKSUM_EN
    load_ck   = 1'b0;
`endif
    case (state_q)
      ST_IDLE:    if (grant && len_sat != '0) state_d = ST_SEND;
      ST_SEND: begin
        tx_dv   = 1'b1;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (i_Tx_Done) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!i_Tx_Done) begin
          if (rem_q != '0) begin
            state_d   = ST_SEND;
            load_next = 1'b1;
          end else begin
`ifdef UART_TX_SCHED_CKSUM_EN
            if (!ck_sent_q) begin
              state_d = ST_CKSUM;
              load_ck = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef UART_TX_SCHED_CKSUM_EN
      ST_CKSUM: begin
        tx_dv   = 1'b1;
        state_d = ST_WAIT_HI;
      end
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
      grant_id_q <= 1'b0;
      tx_byte_q  <= '0;
      sh_q       <= '0;
      rem_q      <= '0;
`ifdef UART_TX_SCHED_CKSUM_EN
      cksum_q    <= '0;
      ck_sent_q  <= 1'b0;
`endif
    end else begin
      ready0_q <= grant & ~gnt_id;
      ready1_q <= grant & gnt_id;
      if (grant) begin
        grant_id_q <= gnt_id;
        sh_q       <= aligned << BYTE_W;
        rem_q      <= (len_sat != '0) ? len_sat - LEN_W'(1) : '0;
        // A zero-length frame leaves the last transmitted byte on o_Tx_Byte
        if (len_sat != '0) tx_byte_q <= aligned[DATA_W-1 -: BYTE_W];
`ifdef UART_TX_SCHED_CKSUM_EN
        cksum_q    <= aligned[DATA_W-1 -: BYTE_W];
        ck_sent_q  <= 1'b0;
`endif
      end
      if (load_next) begin
        tx_byte_q <= sh_q[DATA_W-1 -: BYTE_W];
        sh_q      <= sh_q << BYTE_W;
        rem_q     <= rem_q - LEN_W'(1);
`ifdef UART_TX_SCHED_CKSUM_EN
        cksum_q   <= cksum_q ^ sh_q[DATA_W-1 -: BYTE_W];
`endif
      end
`ifdef UART_TX_SCHED_CKSUM_EN
      if (load_ck) begin
        tx_byte_q <= cksum_q;
        ck_sent_q <= 1'b1;
      end
`endif
    end
  end

  assign o_REQ0_READY = ready0_q;
  assign o_REQ1_READY = ready1_q;
  assign o_Tx_DV      = tx_dv;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_BUSY       = (state_q != ST_IDLE);
  assign o_GRANT_ID   = grant_id_q;
  assign o_DBG_STATE  = state_q;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Two-requester, round-robin frame scheduler in front of the UART transmitter.
- Each requester submits a frame of 1–4 bytes packed in a 32-bit word.
- The block grants one requester, latches its frame and feeds the transmitter byte by byte, MSB first, using its one-cycle DV strobe and Tx_Done completion.
- It sits between the sensor-data/command-response sources and uart_tx.

Parameters:
- DATA_W, 32, frame word width; must equal 8*MAX_BYTES.
- MAX_BYTES, 4, maximum bytes per frame.
- LEN_W, 3, width of the length field.

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  synchronous active-high reset
- i_REQ0_VALID  in  1  requester 0 has a frame; held until o_REQ0_READY
- i_REQ0_DATA  in  DATA_W  requester 0 frame word
- i_REQ0_LEN  in  LEN_W  requester 0 byte count
- o_REQ0_READY  out  1  one-cycle pulse: frame 0 latched
- i_REQ1_VALID  in  1  requester 1 has a frame
- i_REQ1_DATA  in  DATA_W  requester 1 frame word
- i_REQ1_LEN  in  LEN_W  requester 1 byte count
- o_REQ1_READY  out  1  one-cycle pulse: frame 1 latched
- o_Tx_DV  out  1  one-cycle byte strobe to uart_tx
- o_Tx_Byte  out  8  byte to uart_tx; valid with o_Tx_DV
- i_Tx_Done  in  1  uart_tx done flag; high for two consecutive cycles per byte
- o_BUSY  out  1  high in every state except IDLE
- o_GRANT_ID  out  1  ID of the frame being sent

Behaviour:
- Clock and reset: one clock, i_CLK. Reset is synchronous and active-high on i_RST; i_RST overrides all other activity, including mid-frame.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - The round-robin pointer favours requester 0.
  - Byte counter and checksum register are cleared.
  - A frame in flight is abandoned; the partial byte is left to uart_tx's own reset.
- States are IDLE, SEND, WAIT_HI, WAIT_LO, plus CKSUM when the optional feature is compiled in.
- IDLE:
  - Samples the valids.
  - Only one valid high: that requester is granted.
  - Both valid: the requester not granted last time wins; the pointer updates on every grant.
  - On the grant edge, in the same registered cycle:
    - DATA and LEN are latched.
    - o_REQn_READY pulses high for one cycle.
    - o_GRANT_ID updates.
    - State goes to SEND.
  - Latency from valid sampled in IDLE to READY high: 1 cycle.
- LEN rules:
  - LEN=0: READY still pulses, nothing is transmitted, state returns to IDLE, and the pointer still advances.
  - LEN>MAX_BYTES: saturates to MAX_BYTES.
- Byte order: byte k (k=0..LEN-1) is DATA[8*(LEN-1-k) +: 8], i.e. the low LEN bytes are sent most-significant first.
- SEND:
  - o_Tx_DV=1 for exactly one cycle, with o_Tx_Byte set to byte k.
  - Goes to WAIT_HI.
- WAIT_HI: waits for i_Tx_Done=1, then goes to WAIT_LO.
- WAIT_LO: waits for i_Tx_Done=0; uart_tx is then back in IDLE.
  - If bytes remain: k increments and state goes to SEND.
  - Otherwise: state goes to IDLE (or CKSUM when compiled in).
- Inter-byte gap: from i_Tx_Done falling to the next o_Tx_DV is 1 cycle.
- Waits have no timeout; a stuck uart_tx holds the block in WAIT_HI indefinitely.
- Requester inputs are ignored outside IDLE; a valid raised mid-frame waits.
- A requester must not change DATA/LEN while VALID is high and READY has not yet pulsed.
- o_Tx_Byte holds its last value between strobes.

Optional Feature:
- Macro: UART_TX_SCHED_CKSUM_EN.
- Defined:
  - After the last payload byte's WAIT_LO, state goes to CKSUM.
  - CKSUM pulses o_Tx_DV with the 8-bit XOR of all payload bytes of the frame, then runs WAIT_HI/WAIT_LO and returns to IDLE.
  - The checksum register resets at each grant.
  - A LEN=0 frame sends no checksum.
- Not defined: no CKSUM state and no checksum register; the frame ends after its last payload byte.

Decomposition:
- Package uart_tx_sched_pkg holds:
  - state-encoding localparams;
  - BYTE_W=8;
  - the MAX_BYTES default.
- One sub-module, rr_arb2:
  - combinational grant from two valids plus a pointer;
  - registered pointer update on the grant enable;
  - reset to favour requester 0.

Test Plan:
- Single frame: REQ0 DATA=0x11223344, LEN=4 → READY0 pulse 1 cycle after valid; bytes 0x11,0x22,0x33,0x44 in order; one DV per byte; BUSY falls after the last done falls.
- Contention: both valid, REQ0 0x000000AA LEN=1, REQ1 0x0000BBCC LEN=2 → REQ0 granted first (GRANT_ID=0); then REQ1 sends 0xBB,0xCC; with both re-asserted, REQ0 wins again.
- Boundary lengths:
  - LEN=0 → READY pulses, no DV, back to IDLE.
  - LEN=7 with DATA=0xDEADBEEF → four bytes sent, 0xDE first.
- Reset mid-frame: assert i_RST during WAIT_HI of byte 2 → next cycle all outputs 0, state IDLE; a subsequent REQ1-only frame is granted normally.
- Handshake timing: model done high for 2 cycles → next DV exactly 1 cycle after done falls; no DV while done is high.
- CKSUM_EN build: DATA=0x01020304, LEN=4 → fifth byte 0x04 (0x01^0x02^0x03^0x04); without the macro only 4 bytes are sent.
